// File: rtl/maze_pkg.sv
// Shared types for the maze solver: FSM states, move directions, grid coordinates
// and the neighbour/edge helpers used by the controller.
package maze_pkg;

  localparam int unsigned GRID_W  = 16;
  localparam int unsigned COORD_W = $clog2(GRID_W);
  localparam int unsigned DIR_W   = 2;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  typedef enum logic [2:0] {IDLE, CHK, MARK, TRY, BACK, DONE, FAIL} state_t;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  // Cell one step from c along d; rev walks the opposite way when unwinding the path.
  function automatic cell_t step_cell(input cell_t c, input dir_t d, input logic rev);
    cell_t n;
    dir_t  e;
    n = c;
    e = rev ? dir_t'(d ^ DIR_DOWN) : d;
    case (e)
      DIR_UP:    n.y = c.y - coord_t'(1);
      DIR_RIGHT: n.x = c.x + coord_t'(1);
      DIR_DOWN:  n.y = c.y + coord_t'(1);
      DIR_LEFT:  n.x = c.x - coord_t'(1);
      default:   n = c;
    endcase
    return n;
  endfunction

  // True when stepping from c along d would leave the grid (no wrap-around).
  function automatic logic off_grid(input cell_t c, input dir_t d);
    logic hit;
    case (d)
      DIR_UP:    hit = (c.y == '0);
      DIR_RIGHT: hit = (c.x == coord_t'(GRID_W - 1));
      DIR_DOWN:  hit = (c.y == coord_t'(GRID_W - 1));
      DIR_LEFT:  hit = (c.x == '0);
      default:   hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/maze_solver_ctrl_if.sv
// Controller-side buses: single-bit maze memory port and solution-replay stream.
interface maze_solver_ctrl_if;
  import maze_pkg::*;

  coord_t           mem_x;
  coord_t           mem_y;
  logic             mem_wr;
  logic             mem_rd;
  logic             mem_din;
  logic             mem_dout;
  logic             move_valid;
  logic             move_ready;
  logic [DIR_W-1:0] move_dir;
  logic             move_last;

  modport master (
    output mem_x, mem_y, mem_wr, mem_rd, mem_din,
    input  mem_dout,
    output move_valid, move_dir, move_last,
    input  move_ready
  );

  modport slave (
    input  mem_x, mem_y, mem_wr, mem_rd, mem_din,
    output mem_dout,
    input  move_valid, move_dir, move_last,
    output move_ready
  );

endinterface

// File: rtl/maze_dir_stack.sv
// LIFO of 2-bit move directions with a random-access read port for path replay.
module maze_dir_stack
  import maze_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 256,
  parameter int unsigned PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [DIR_W-1:0] push_dir,
  input  logic             pop,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [DIR_W-1:0] rd_dir,
  output logic [DIR_W-1:0] top_dir,
  output logic [PTR_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DIR_W-1:0] mem [STACK_DEPTH];

  assign full    = (level == PTR_W'(STACK_DEPTH));
  assign empty   = (level == '0);
  assign top_dir = mem[IDX_W'(level - PTR_W'(1))];
  assign rd_dir  = mem[IDX_W'(rd_addr)];

  // Storage carries no reset; only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[IDX_W'(level)] <= push_dir;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (clr) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + PTR_W'(1);
    end else if (pop && !empty) begin
      level <= level - PTR_W'(1);
    end
  end

endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver: marks visited cells, backtracks via a direction stack and
// replays the found path. Optional MAZE_STEP_COUNT_EN builds the search-cycle counter.
module maze_solver_ctrl
  import maze_pkg::*;
#(
  parameter coord_t      GOAL_X      = 4'd15,
  parameter coord_t      GOAL_Y      = 4'd15,
  parameter int unsigned STACK_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  maze_solver_ctrl_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [15:0]        step_count
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);

  state_t           state, state_nxt;
  cell_t            cur, cur_nxt;
  logic [2:0]       dir, dir_nxt;
  logic [PTR_W-1:0] rp, rp_nxt;
  logic [PTR_W-1:0] sp;
  logic             push, pop, clr, full, empty;
  logic [DIR_W-1:0] top_dir, rd_dir;
  cell_t            nbr, back_cell;
  dir_t             try_dir;
  logic             blocked, start_acc, move_fire, replay_valid;

  assign try_dir   = dir_t'(dir[DIR_W-1:0]);
  assign nbr       = step_cell(cur, try_dir, 1'b0);
  assign back_cell = step_cell(cur, dir_t'(top_dir), 1'b1);
  assign blocked   = off_grid(cur, try_dir);
  assign start_acc = start && ((state == IDLE) || (state == DONE) || (state == FAIL));
  assign move_fire = replay_valid && bus.move_ready;

  maze_dir_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .PTR_W       (PTR_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .push_dir (dir[DIR_W-1:0]),
    .pop      (pop),
    .rd_addr  (rp),
    .rd_dir   (rd_dir),
    .top_dir  (top_dir),
    .level    (sp),
    .full     (full),
    .empty    (empty)
  );

  // Memory port depends only on registered state so the read data can steer next-state.
  always_comb begin
    bus.mem_x   = '0;
    bus.mem_y   = '0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.mem_din = 1'b0;
    case (state)
      CHK: begin
        bus.mem_rd = 1'b1;
        bus.mem_x  = cur.x;
        bus.mem_y  = cur.y;
      end
      MARK: begin
        bus.mem_wr  = 1'b1;
        bus.mem_din = 1'b1;
        bus.mem_x   = cur.x;
        bus.mem_y   = cur.y;
      end
      TRY: begin
        if ((dir != 3'd4) && !blocked) begin
          bus.mem_rd = 1'b1;
          bus.mem_x  = nbr.x;
          bus.mem_y  = nbr.y;
        end
      end
      default: ;
    endcase
  end

  // Replay stream reads the stack bottom-up while rp trails sp.
  always_comb begin
    replay_valid   = (state == DONE) && (rp < sp);
    bus.move_valid = replay_valid;
    bus.move_dir   = replay_valid ? rd_dir : '0;
    bus.move_last  = replay_valid && (rp == sp - PTR_W'(1));
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    dir_nxt   = dir;
    rp_nxt    = rp;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    if (start_acc) begin
      state_nxt = CHK;
      cur_nxt   = '0;
      dir_nxt   = '0;
      clr       = 1'b1;
    end else begin
      case (state)
        CHK: state_nxt = bus.mem_dout ? FAIL : MARK;
        MARK: begin
          if ((cur.x == GOAL_X) && (cur.y == GOAL_Y)) begin
            state_nxt = DONE;
            rp_nxt    = '0;
          end else begin
            dir_nxt   = '0;
            state_nxt = TRY;
          end
        end
        TRY: begin
          if (dir == 3'd4) begin
            state_nxt = BACK;
          end else if (blocked || bus.mem_dout) begin
            dir_nxt = dir + 3'd1;
          end else if (full) begin
            state_nxt = FAIL;
          end else begin
            push      = 1'b1;
            cur_nxt   = nbr;
            state_nxt = MARK;
          end
        end
        BACK: begin
          if (empty) begin
            state_nxt = FAIL;
          end else begin
            pop       = 1'b1;
            cur_nxt   = back_cell;
            dir_nxt   = {1'b0, top_dir} + 3'd1;
            state_nxt = TRY;
          end
        end
        DONE: begin
          if (move_fire) begin
            rp_nxt = rp + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      dir   <= '0;
      rp    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      dir   <= dir_nxt;
      rp    <= rp_nxt;
      busy  <= (state_nxt == CHK) || (state_nxt == MARK) ||
               (state_nxt == TRY) || (state_nxt == BACK);
      done  <= (state_nxt == DONE);
      fail  <= (state_nxt == FAIL);
    end
  end

`ifdef MAZE_STEP_COUNT_EN
  logic [15:0] step_q;

  // Saturating count of busy cycles since the last accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else if (start_acc) begin
      step_q <= '0;
    end else if (busy && (step_q != 16'hFFFF)) begin
      step_q <= step_q + 16'd1;
    end
  end

  assign step_count = step_q;
`else
  assign step_count = 16'd0;
`endif

endmodule
